mc_sequencer: RTL and testbench
===============================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  6  IR[31:26]; encodings per definitions.vh (RTYPE 000000, J 000010, JAL 000011, BEQ 000100, BNE 000101, ADDI 001000, ADDIU 001001, SLTI 001010, ANDI 001100, ORI 001101, LW 100011, SW 101011).
REQ-005 funct  input  6  IR[5:0]; JR 001000, SYSCALL 001100.
REQ-006 zero  input  1  ALU equality flag, sampled in EXEC.
REQ-007 halt_cond  input  1  syscall exit condition ($v0==10), sampled in EXEC.
REQ-008 imem_ready / dmem_ready  input  1 each  memory completion strobes.
REQ-009 imem_req  output  1  instruction fetch request.
REQ-010 ir_we  output  1  instruction register load strobe.
REQ-011 dmem_req / dmem_we  output  1 each  data request / write qualifier.
REQ-012 pc_we  output  1  PC load strobe; pc_sel  output  2  00 PC+4, 01 branch target, 10 jump target, 11 rs (JR).
REQ-013 rf_we  output  1  register file write strobe; wb_sel  output  2  00 ALU, 01 memory, 10 PC+4; rf_dst  output  2  00 rt, 01 rd, 10 $31.
REQ-014 retired  output  1  one-cycle pulse per completed instruction; instr_cnt  output  CNT_W  retired count.
REQ-015 halted  output  1  core stopped; illegal  output  1  one-cycle pulse on unknown opcode/funct.

Function
REQ-016 States: FETCH, DECODE, EXEC, MEM, WB, HALT; encoding is implementation choice.
REQ-017 FETCH: imem_req=1; on imem_ready, ir_we=1 for that cycle and next state DECODE; otherwise stay.
REQ-018 DECODE: one cycle, all strobes 0, next EXEC; opcode/funct registered here and used through WB.
REQ-019 EXEC, R-type ALU (ADD, ADDU, SUB, AND, OR, NOR, SLT, SLTU, SLL, SRL, SRA) and immediate ALU (ADDI, ADDIU, SLTI, ANDI, ORI): next WB.
REQ-020 EXEC, LW/SW: next MEM.
REQ-021 EXEC, BEQ/BNE: pc_we=1, pc_sel=01 if taken (BEQ: zero=1; BNE: zero=0) else 00; retire; next FETCH.
REQ-022 EXEC, J: pc_we=1, pc_sel=10, retire, next FETCH; JR: pc_we=1, pc_sel=11, retire, next FETCH; JAL: next WB.
REQ-023 EXEC, SYSCALL: halt_cond=1 -> retire, next HALT, PC not written; halt_cond=0 -> pc_we=1, pc_sel=00, retire, next FETCH.
REQ-024 EXEC, unknown opcode or funct: illegal=1, pc_we=1, pc_sel=00, retire, next FETCH (treated as NOP).
REQ-025 MEM: dmem_req=1, dmem_we=1 only for SW, both held stable until dmem_ready; on dmem_ready SW does pc_we=1 pc_sel=00, retires, next FETCH; LW next WB.
REQ-026 WB: rf_we=1, pc_we=1, retire, next FETCH; R-type: rf_dst=01 wb_sel=00 pc_sel=00; immediate: rf_dst=00 wb_sel=00 pc_sel=00; LW: rf_dst=00 wb_sel=01 pc_sel=00; JAL: rf_dst=10 wb_sel=10 pc_sel=10.
REQ-027 HALT: halted=1, all strobes 0, absorbing until rst.
REQ-028 Strobes (imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, retired, illegal) are 0 in every state/condition not listed; at most one of imem_req/dmem_req high per cycle.
REQ-029 Mux selects are don't-care when their strobe is 0 but SHALL be driven 0 then.
REQ-030 imem_ready outside FETCH and dmem_ready outside MEM are ignored.
REQ-031 instr_cnt increments by 1 on each retired pulse, wraps from 2^CNT_W-1 to 0.
REQ-032 Latency with same-cycle ready: branch/J/JR/SYSCALL 3 cycles, R/imm/SW/JAL 4, LW 5; each wait cycle on ready adds 1.

Reset
REQ-033 rst=1 at a clock edge forces FETCH, instr_cnt=0, halted=0, from any state including mid-MEM or HALT; rst dominates simultaneous ready.
REQ-034 During and the cycle after reset all strobes except imem_req are 0; imem_req=1 in the first post-reset FETCH cycle.

Verification
REQ-035 ADD, ready tied 1: strobe sequence imem_req+ir_we, idle, idle, rf_we+pc_we(sel 00, rf_dst 01)+retired; instr_cnt 0->1.
REQ-036 LW with dmem_ready delayed 3 cycles: dmem_req/dmem_we=1/0 held 4 cycles, then WB with wb_sel=01 rf_dst=00; total 8 cycles.
REQ-037 BEQ zero=1 -> pc_sel=01; BNE zero=1 -> pc_sel=00; each retires in 3 cycles, no rf_we.
REQ-038 JAL -> WB cycle rf_dst=10 wb_sel=10 pc_sel=10 pc_we=1; JR -> EXEC pc_sel=11.
REQ-039 SYSCALL halt_cond=1 -> halted=1 next cycle, no further imem_req for 20 cycles; rst -> FETCH, instr_cnt=0.
REQ-040 CNT_W=4, 16 NOPs (SLL) retired -> instr_cnt wraps to 0; rst asserted mid-MEM on SW with dmem_ready=1 same cycle -> no retire, FETCH next.

Source files
------------

// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mc_sequencer
// Function : Multi-cycle MIPS-subset control sequencer
//            (FETCH/DECODE/EXEC/MEM/WB/HALT) with a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module mc_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             halt_cond,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [1:0]       rf_dst,
    output logic             retired,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             halted,
    output logic             illegal
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_HALT   = 3'd5;

    localparam logic [3:0] c_ALUR = 4'd0;
    localparam logic [3:0] c_ALUI = 4'd1;
    localparam logic [3:0] c_LW   = 4'd2;
    localparam logic [3:0] c_SW   = 4'd3;
    localparam logic [3:0] c_BEQ  = 4'd4;
    localparam logic [3:0] c_BNE  = 4'd5;
    localparam logic [3:0] c_J    = 4'd6;
    localparam logic [3:0] c_JR   = 4'd7;
    localparam logic [3:0] c_JAL  = 4'd8;
    localparam logic [3:0] c_SYS  = 4'd9;
    localparam logic [3:0] c_ILL  = 4'd10;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [5:0] r_op;
    logic [5:0] r_fn;
    logic [3:0] w_cls;

    // IR is stable during DECODE; the latched copy steers EXEC through WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= 6'd0;
            r_fn <= 6'd0;
        end else if (r_state == c_DECODE) begin
            r_op <= opcode;
            r_fn <= funct;
        end
    end

    always_comb begin
        w_cls = c_ILL;
        case (r_op)
            6'b000000: begin
                case (r_fn)
                    6'b100000, 6'b100001, 6'b100010, 6'b100100, 6'b100101,
                    6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                    6'b000011: w_cls = c_ALUR;
                    6'b001000: w_cls = c_JR;
                    6'b001100: w_cls = c_SYS;
                    default:   w_cls = c_ILL;
                endcase
            end
            6'b000010: w_cls = c_J;
            6'b000011: w_cls = c_JAL;
            6'b000100: w_cls = c_BEQ;
            6'b000101: w_cls = c_BNE;
            6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101: w_cls = c_ALUI;
            6'b100011: w_cls = c_LW;
            6'b101011: w_cls = c_SW;
            default:   w_cls = c_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_FETCH:  if (imem_ready) w_next = c_DECODE;
            c_DECODE: w_next = c_EXEC;
            c_EXEC: begin
                case (w_cls)
                    c_ALUR, c_ALUI, c_JAL: w_next = c_WB;
                    c_LW, c_SW:            w_next = c_MEM;
                    c_SYS:                 w_next = halt_cond ? c_HALT : c_FETCH;
                    default:               w_next = c_FETCH;
                endcase
            end
            c_MEM:    if (dmem_ready) w_next = (w_cls == c_SW) ? c_FETCH : c_WB;
            c_WB:     w_next = c_FETCH;
            c_HALT:   w_next = c_HALT;
            default:  w_next = c_FETCH;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        rf_we    = 1'b0;
        wb_sel   = 2'b00;
        rf_dst   = 2'b00;
        retired  = 1'b0;
        illegal  = 1'b0;
        case (r_state)
            c_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            c_EXEC: begin
                case (w_cls)
                    c_BEQ: begin
                        pc_we = 1'b1; retired = 1'b1;
                        pc_sel = zero ? 2'b01 : 2'b00;
                    end
                    c_BNE: begin
                        pc_we = 1'b1; retired = 1'b1;
                        pc_sel = zero ? 2'b00 : 2'b01;
                    end
                    c_J:   begin pc_we = 1'b1; pc_sel = 2'b10; retired = 1'b1; end
                    c_JR:  begin pc_we = 1'b1; pc_sel = 2'b11; retired = 1'b1; end
                    c_SYS: begin pc_we = ~halt_cond; retired = 1'b1; end
                    c_ILL: begin pc_we = 1'b1; retired = 1'b1; illegal = 1'b1; end
                    default: ;
                endcase
            end
            c_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (w_cls == c_SW);
                if (dmem_ready && (w_cls == c_SW)) begin
                    pc_we   = 1'b1;
                    retired = 1'b1;
                end
            end
            c_WB: begin
                rf_we = 1'b1; pc_we = 1'b1; retired = 1'b1;
                case (w_cls)
                    c_ALUR: rf_dst = 2'b01;
                    c_LW:   wb_sel = 2'b01;
                    c_JAL:  begin rf_dst = 2'b10; wb_sel = 2'b10; pc_sel = 2'b10; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        // Reset overrides whatever state was active, including a completing MEM.
        if (rst) begin
            imem_req = 1'b0; ir_we = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0;
            pc_we = 1'b0; pc_sel = 2'b00; rf_we = 1'b0; wb_sel = 2'b00;
            rf_dst = 2'b00; retired = 1'b0; illegal = 1'b0;
        end
    end

    assign halted = (r_state == c_HALT);

    always_ff @(posedge clk) begin
        if (rst)          instr_cnt <= '0;
        else if (retired) instr_cnt <= instr_cnt + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_sequencer
// Function : Cycle-table and directed-sequence bench for mc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_sequencer;

    localparam logic [7:0] c_IMR = 8'h80, c_IRW = 8'h40, c_DRQ = 8'h20, c_DWE = 8'h10;
    localparam logic [7:0] c_PCW = 8'h08, c_RFW = 8'h04, c_RET = 8'h02, c_ILL = 8'h01;
    localparam logic [5:0] c_RT = 6'd0, c_J = 6'd2, c_JAL = 6'd3, c_BEQ = 6'd4, c_BNE = 6'd5;
    localparam logic [5:0] c_ADDI = 6'd8, c_LW = 6'b100011, c_SW = 6'b101011;
    localparam logic [5:0] c_ADD = 6'b100000, c_SLL = 6'd0, c_JRF = 6'b001000, c_SYS = 6'b001100;

    logic clk = 1'b0;
    logic rst, zero, halt_cond, imem_ready, dmem_ready;
    logic [5:0] opcode, funct;
    logic imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, retired, halted, illegal;
    logic [1:0] pc_sel, wb_sel, rf_dst;
    logic [3:0] instr_cnt;

    always #5 clk = ~clk;

    mc_sequencer #(.CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .halt_cond(halt_cond), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .rf_dst(rf_dst), .retired(retired), .instr_cnt(instr_cnt),
        .halted(halted), .illegal(illegal)
    );

    typedef struct {
        logic       rst;
        logic [5:0] op, fn;
        logic       z, hc, ir, dr;
        logic [7:0] strb;
        logic [1:0] pcs, wbs, dst;
        logic       halt;
    } vec_t;

    vec_t tv[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [3:0] m_cnt = 4'd0;
    logic [7:0] act, msk;
    int   cyc, mem;
    logic done;
    logic [3:0] c0, c_exp;

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic hc, input logic ir, input logic dr,
                       input logic [7:0] s, input logic [1:0] pcs, input logic [1:0] wbs,
                       input logic [1:0] dst, input logic h);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.z = z; v.hc = hc; v.ir = ir; v.dr = dr;
        v.strb = s; v.pcs = pcs; v.wbs = wbs; v.dst = dst; v.halt = h;
        tv.push_back(v);
    endtask

    // FETCH with same-cycle imem_ready followed by the idle DECODE cycle
    task automatic fd(input logic [5:0] op, input logic [5:0] fn);
        add(0, op, fn, 0, 0, 1, 0, c_IMR | c_IRW, 2'b00, 2'b00, 2'b00, 0);
        add(0, op, fn, 0, 0, 1, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0);
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; opcode = v.op; funct = v.fn; zero = v.z;
        halt_cond = v.hc; imem_ready = v.ir; dmem_ready = v.dr;
    endtask

    initial begin
        add(1, c_RT, c_ADD, 0, 0, 1, 1, 8'h00, 2'b00, 2'b00, 2'b00, 0);
        add(1, c_RT, c_ADD, 0, 0, 1, 1, 8'h00, 2'b00, 2'b00, 2'b00, 0);
        fd(c_RT, c_ADD);
        add(0, c_RT, c_ADD, 0, 0, 1, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0);
        add(0, c_RT, c_ADD, 0, 0, 1, 0, c_PCW | c_RFW | c_RET, 2'b00, 2'b00, 2'b01, 0);
        fd(c_LW, 6'd0);
        add(0, c_LW, 6'd0, 0, 0, 1, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0);
        for (int i = 0; i < 3; i++)
            add(0, c_LW, 6'd0, 0, 0, 1, 0, c_DRQ, 2'b00, 2'b00, 2'b00, 0);
        add(0, c_LW, 6'd0, 0, 0, 1, 1, c_DRQ, 2'b00, 2'b00, 2'b00, 0);
        add(0, c_LW, 6'd0, 0, 0, 1, 0, c_PCW | c_RFW | c_RET, 2'b00, 2'b01, 2'b00, 0);
        fd(c_BEQ, 6'd0);
        add(0, c_BEQ, 6'd0, 1, 0, 1, 0, c_PCW | c_RET, 2'b01, 2'b00, 2'b00, 0);
        fd(c_BNE, 6'd0);
        add(0, c_BNE, 6'd0, 1, 0, 1, 0, c_PCW | c_RET, 2'b00, 2'b00, 2'b00, 0);
        fd(c_BNE, 6'd0);
        add(0, c_BNE, 6'd0, 0, 0, 1, 0, c_PCW | c_RET, 2'b01, 2'b00, 2'b00, 0);
        fd(c_JAL, 6'd0);
        add(0, c_JAL, 6'd0, 0, 0, 1, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0);
        add(0, c_JAL, 6'd0, 0, 0, 1, 0, c_PCW | c_RFW | c_RET, 2'b10, 2'b10, 2'b10, 0);
        fd(c_RT, c_JRF);
        add(0, c_RT, c_JRF, 0, 0, 1, 0, c_PCW | c_RET, 2'b11, 2'b00, 2'b00, 0);
        fd(c_J, 6'd0);
        add(0, c_J, 6'd0, 0, 0, 1, 0, c_PCW | c_RET, 2'b10, 2'b00, 2'b00, 0);
        add(0, c_ADDI, 6'd0, 0, 0, 0, 0, c_IMR, 2'b00, 2'b00, 2'b00, 0);
        fd(c_ADDI, 6'd0);
        add(0, c_ADDI, 6'd0, 0, 0, 1, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0);
        add(0, c_ADDI, 6'd0, 0, 0, 1, 0, c_PCW | c_RFW | c_RET, 2'b00, 2'b00, 2'b00, 0);
        fd(6'h3F, 6'd0);
        add(0, 6'h3F, 6'd0, 0, 0, 1, 0, c_PCW | c_RET | c_ILL, 2'b00, 2'b00, 2'b00, 0);
        fd(c_RT, 6'h01);
        add(0, c_RT, 6'h01, 0, 0, 1, 0, c_PCW | c_RET | c_ILL, 2'b00, 2'b00, 2'b00, 0);
        // stray dmem_ready before MEM must not advance anything
        add(0, c_SW, 6'd0, 0, 0, 1, 1, c_IMR | c_IRW, 2'b00, 2'b00, 2'b00, 0);
        add(0, c_SW, 6'd0, 0, 0, 1, 1, 8'h00, 2'b00, 2'b00, 2'b00, 0);
        add(0, c_SW, 6'd0, 0, 0, 1, 1, 8'h00, 2'b00, 2'b00, 2'b00, 0);
        add(0, c_SW, 6'd0, 0, 0, 1, 1, c_DRQ | c_DWE | c_PCW | c_RET, 2'b00, 2'b00, 2'b00, 0);
        fd(c_RT, c_SYS);
        add(0, c_RT, c_SYS, 0, 0, 1, 0, c_PCW | c_RET, 2'b00, 2'b00, 2'b00, 0);
        fd(c_RT, c_SYS);
        add(0, c_RT, c_SYS, 0, 1, 1, 0, c_RET, 2'b00, 2'b00, 2'b00, 0);
        for (int i = 0; i < 20; i++)
            add(0, c_RT, c_SYS, 0, 1, 1, 1, 8'h00, 2'b00, 2'b00, 2'b00, 1);
        add(1, c_RT, c_SYS, 0, 1, 1, 1, 8'h00, 2'b00, 2'b00, 2'b00, 0);
        add(0, c_RT, c_SLL, 0, 0, 0, 0, c_IMR, 2'b00, 2'b00, 2'b00, 0);
        for (int i = 0; i < 16; i++) begin
            fd(c_RT, c_SLL);
            add(0, c_RT, c_SLL, 0, 0, 1, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0);
            add(0, c_RT, c_SLL, 0, 0, 1, 0, c_PCW | c_RFW | c_RET, 2'b00, 2'b00, 2'b01, 0);
        end
        add(0, c_RT, c_ADD, 0, 0, 0, 0, c_IMR, 2'b00, 2'b00, 2'b00, 0);
        fd(c_RT, c_ADD);
        add(0, c_RT, c_ADD, 0, 0, 1, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0);
        add(0, c_RT, c_ADD, 0, 0, 1, 0, c_PCW | c_RFW | c_RET, 2'b00, 2'b00, 2'b01, 0);
        fd(c_SW, 6'd0);
        add(0, c_SW, 6'd0, 0, 0, 1, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0);
        add(0, c_SW, 6'd0, 0, 0, 1, 0, c_DRQ | c_DWE, 2'b00, 2'b00, 2'b00, 0);
        add(1, c_SW, 6'd0, 0, 0, 1, 1, 8'h00, 2'b00, 2'b00, 2'b00, 0);
        add(0, c_SW, 6'd0, 0, 0, 0, 0, c_IMR, 2'b00, 2'b00, 2'b00, 0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            @(negedge clk);
            act = {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, retired, illegal};
            msk = tv[i].rst ? 8'h7F : 8'hFF;
            n_vec++;
            if (((act & msk) !== (tv[i].strb & msk)) || pc_sel !== tv[i].pcs ||
                wb_sel !== tv[i].wbs || rf_dst !== tv[i].dst ||
                (!tv[i].rst && halted !== tv[i].halt) || instr_cnt !== m_cnt) begin
                n_err++;
                $display("FAIL vec%0d: got strb=%b pcs=%b wbs=%b dst=%b halt=%b cnt=%0d, need strb=%b pcs=%b wbs=%b dst=%b halt=%b cnt=%0d",
                         i, act, pc_sel, wb_sel, rf_dst, halted, instr_cnt,
                         tv[i].strb, tv[i].pcs, tv[i].wbs, tv[i].dst, tv[i].halt, m_cnt);
            end
            if (tv[i].rst)                m_cnt = 4'd0;
            else if (tv[i].strb & c_RET)  m_cnt = m_cnt + 4'd1;
            @(posedge clk); #1;
        end

        // LW latency with 0..2 dmem stall cycles: expect 5 + stalls
        for (int d = 0; d < 3; d++) begin
            c0 = instr_cnt; cyc = 0; mem = 0; done = 1'b0;
            rst = 1'b0; opcode = c_LW; funct = 6'd0; zero = 1'b0; halt_cond = 1'b0;
            imem_ready = 1'b1; dmem_ready = 1'b0;
            while (!done && cyc < 30) begin
                dmem_ready = 1'b0;
                #1;
                if (dmem_req) begin
                    if (mem >= d) dmem_ready = 1'b1;
                    mem++;
                end
                #1;
                cyc++;
                if (retired) done = 1'b1;
                @(posedge clk); #1;
            end
            imem_ready = 1'b0; dmem_ready = 1'b0;
            c_exp = c0 + 4'd1;
            n_vec++;
            if (!done || cyc != 5 + d || instr_cnt !== c_exp) begin
                n_err++;
                $display("FAIL lw_stall%0d: got done=%b cycles=%0d cnt=%0d, need done=1 cycles=%0d cnt=%0d",
                         d, done, cyc, instr_cnt, 5 + d, c_exp);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
